// File: rtl/mul_seq_ctrl_if.sv
// Bundle for mul_seq_ctrl: request handshake, result handshake and the link to the
// shared 32-bit arithmetic unit.
//   slave  : the multiply controller (receives a/b/signed_op/in_valid/out_ready and
//            the unit's sum/carry; drives in_ready, prod, out_valid and the unit's
//            operand and function inputs).
//   master : the surrounding logic (decode stage, write-back, arithmetic unit).
interface mul_seq_ctrl_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_op;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_f0;
  logic        alu_f1;
  logic [31:0] alu_s;
  logic        alu_c;

  modport slave (
    input  a, b, signed_op, in_valid, out_ready, alu_s, alu_c,
    output in_ready, prod, out_valid, alu_a, alu_b, alu_f0, alu_f1
  );

  modport master (
    output a, b, signed_op, in_valid, out_ready, alu_s, alu_c,
    input  in_ready, prod, out_valid, alu_a, alu_b, alu_f0, alu_f1
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32->64 multiplier controller. Computes signed or unsigned products by
// time-multiplexing a shared 32-bit arithmetic unit (f1f0: 00 A+B, 01 A-B, 10 -B, 11 B+1).
// Operands are converted to magnitudes, multiplied by 32 shift-add steps, and the
// 64-bit result is negated in two halves when the operand signs differ.
// Fixed latency: 36 cycles from accept to out_valid.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : request/result handshakes and arithmetic-unit link (slave side)
module mul_seq_ctrl #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StIter,
    StNegLo,
    StNegHi,
    StDone
  } state_e;

  state_e      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sgn;
  logic        r_neg;
  logic [31:0] r_mcand;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_nc;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic        r_in_ready;
  logic        r_out_valid;

  logic        w_sgn_in;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [1:0]  w_alu_f;

  assign w_sgn_in = SIGNED_EN & io_bus.signed_op;

  // Arithmetic-unit drive, combinational from state and registers.
  always_comb begin
    w_alu_a = 32'd0;
    w_alu_b = 32'd0;
    w_alu_f = 2'b00;
    case (r_state)
      StNegA: begin
        w_alu_b = r_a;
        if (r_sgn && r_a[31]) w_alu_f = 2'b10;
      end
      StNegB: begin
        w_alu_b = r_b;
        if (r_sgn && r_b[31]) w_alu_f = 2'b10;
      end
      StIter: begin
        w_alu_a = r_lo[0] ? r_mcand : 32'd0;
        w_alu_b = r_hi;
      end
      StNegLo: begin
        w_alu_b = r_lo;
        if (r_neg) w_alu_f = 2'b10;
      end
      StNegHi: begin
        // Upper half of a 64-bit negate: ~hi, plus the borrow-through from the low half.
        if (r_neg) begin
          w_alu_b = ~r_hi;
          w_alu_f = r_nc ? 2'b11 : 2'b00;
        end else begin
          w_alu_b = r_hi;
        end
      end
      default: ;
    endcase
  end

  assign io_bus.alu_a     = w_alu_a;
  assign io_bus.alu_b     = w_alu_b;
  assign io_bus.alu_f1    = w_alu_f[1];
  assign io_bus.alu_f0    = w_alu_f[0];
  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.prod      = r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_sgn       <= 1'b0;
      r_neg       <= 1'b0;
      r_mcand     <= 32'd0;
      r_lo        <= 32'd0;
      r_hi        <= 32'd0;
      r_nc        <= 1'b0;
      r_cnt       <= 5'd0;
      r_prod      <= 64'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_a        <= io_bus.a;
            r_b        <= io_bus.b;
            r_sgn      <= w_sgn_in;
            r_neg      <= w_sgn_in & (io_bus.a[31] ^ io_bus.b[31]);
            r_in_ready <= 1'b0;
            r_state    <= StNegA;
          end
        end
        StNegA: begin
          r_mcand <= io_bus.alu_s;
          r_state <= StNegB;
        end
        StNegB: begin
          r_lo    <= io_bus.alu_s;
          r_hi    <= 32'd0;
          r_cnt   <= 5'd0;
          r_state <= StIter;
        end
        StIter: begin
          // Shift the 65-bit {carry, sum, lo} right by one; lo's LSB selects the next addend.
          r_hi  <= {io_bus.alu_c, io_bus.alu_s[31:1]};
          r_lo  <= {io_bus.alu_s[0], r_lo[31:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= StNegLo;
        end
        StNegLo: begin
          r_lo    <= io_bus.alu_s;
          // Carry out of -lo is set only when lo was zero.
          r_nc    <= r_neg ? io_bus.alu_c : 1'b0;
          r_state <= StNegHi;
        end
        StNegHi: begin
          r_hi        <= io_bus.alu_s;
          r_prod      <= {io_bus.alu_s, r_lo};
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl. Models the shared arithmetic unit combinationally,
// runs hand-computed multiplies and checks latency, handshakes, backpressure and reset.
module tb_mul_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  mul_seq_ctrl_if bus ();

  mul_seq_ctrl #(.SIGNED_EN(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic unit model.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = 33'd0;
    case ({bus.alu_f1, bus.alu_f0})
      2'b00:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01:   alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
      2'b10:   alu_sum = {1'b0, ~bus.alu_b} + 33'd1;
      default: alu_sum = {1'b0, bus.alu_b} + 33'd1;
    endcase
    bus.alu_s = alu_sum[31:0];
    bus.alu_c = alu_sum[32];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [1:0] f_nega;
  logic [1:0] f_neglo;
  logic [1:0] f_neghi;

  // Accept one operation and follow it to the result. With hs=1, out_ready is expected
  // high and the handshake / in_ready return is checked as well.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input bit hs, input string tag);
    bit early_valid;
    bit busy_ready;
    early_valid = 1'b0;
    busy_ready  = 1'b0;
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.signed_op = s;
    bus.in_valid  = 1'b1;
    check_eq({tag, ".ready_idle"}, {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    for (int j = 0; j < 36; j++) begin
      @(negedge clk);
      if (j == 0) bus.in_valid = 1'b0;
      if (bus.out_valid) early_valid = 1'b1;
      if (bus.in_ready) busy_ready = 1'b1;
      if (j == 0)  f_nega  = {bus.alu_f1, bus.alu_f0};
      if (j == 34) f_neglo = {bus.alu_f1, bus.alu_f0};
      if (j == 35) f_neghi = {bus.alu_f1, bus.alu_f0};
    end
    check_eq({tag, ".no_early_valid"}, {63'd0, early_valid}, 64'd0);
    check_eq({tag, ".busy_not_ready"}, {63'd0, busy_ready}, 64'd0);
    @(negedge clk);
    check_eq({tag, ".valid_at_36"}, {63'd0, bus.out_valid}, 64'd1);
    check_eq({tag, ".prod"}, bus.prod, exp);
    if (hs) begin
      @(negedge clk);
      check_eq({tag, ".ready_after_hs"}, {63'd0, bus.in_ready}, 64'd1);
      check_eq({tag, ".valid_after_hs"}, {63'd0, bus.out_valid}, 64'd0);
    end
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.signed_op = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst.in_ready",  {63'd0, bus.in_ready}, 64'd1);
    check_eq("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst.prod",      bus.prod, 64'd0);
    check_eq("rst.alu_a",     {32'd0, bus.alu_a}, 64'd0);
    check_eq("rst.alu_b",     {32'd0, bus.alu_b}, 64'd0);
    check_eq("rst.alu_f",     {62'd0, bus.alu_f1, bus.alu_f0}, 64'd0);
    rst_n = 1'b1;

    run_op(32'd30, 32'd7, 1'b0, 64'h0000_0000_0000_00D2, 1'b1, "u30x7");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1, "umax");
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "sm3x7");
    check_eq("sm3x7.f_nega",  {62'd0, f_nega}, 64'd2);
    check_eq("sm3x7.f_neglo", {62'd0, f_neglo}, 64'd2);
    run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 1'b1, "ufffd_x7");
    check_eq("ufffd_x7.f_nega", {62'd0, f_nega}, 64'd0);
    run_op(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'd15, 1'b1, "sm3xm5");
    check_eq("sm3xm5.f_neglo", {62'd0, f_neglo}, 64'd0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1, "smin2");
    run_op(32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0, 1'b1, "s0xm5");
    check_eq("s0xm5.f_neghi", {62'd0, f_neghi}, 64'd3);

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
    bus.out_ready = 1'b0;
    run_op(32'd123456, 32'd1000, 1'b0, 64'd123456000, 1'b0, "bp");
    begin
      bit bp_bad;
      bp_bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        bus.in_valid = k[0];
        bus.a        = 32'd9;
        if (bus.prod !== 64'd123456000 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
          bp_bad = 1'b1;
      end
      check_eq("bp.stall_stable", {63'd0, bp_bad}, 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp.ready_after_release", {63'd0, bus.in_ready}, 64'd1);
    check_eq("bp.valid_after_release", {63'd0, bus.out_valid}, 64'd0);
    check_eq("bp.prod_kept", bus.prod, 64'd123456000);

    // Asynchronous reset in the middle of the iteration phase.
    bus.a         = 32'd1234;
    bus.b         = 32'd5678;
    bus.signed_op = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("mid.busy", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("arst.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("arst.prod",      bus.prod, 64'd0);
    check_eq("arst.in_ready",  {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd5, 32'd6, 1'b0, 64'd30, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller that computes a 32×32→64-bit product, signed or unsigned, by time-multiplexing the team's shared 32-bit arithmetic unit. The unit's four function codes are: f1f0=00 A+B, 01 A−B, 10 −B, 11 B+1. The block owns the unit's operand and function inputs and samples its sum/carry outputs. It sits between the instruction-decode stage and the register write-back path. The multiply has a valid/ready handshake on both sides and a fixed 36-cycle latency.

## Interface
- SIGNED_EN, 1 — when 0, `signed_op` is ignored and every operation is unsigned.
- clk  in  1  — single clock; all state updates on rising edge.
- rst_n  in  1  — **asynchronous, active-low reset**.
- a  in  32  — multiplicand, sampled on accept.
- b  in  32  — multiplier, sampled on accept.
- signed_op  in  1  — 1: two's-complement operands; 0: unsigned. Sampled on accept.
- in_valid  in  1  — request present.
- in_ready  out  1  — block idle; accept when `in_valid & in_ready`.
- prod  out  64  — product, registered. Valid while `out_valid`=1.
- out_valid  out  1  — result available.
- out_ready  in  1  — consumer takes the result when `out_valid & out_ready`.
- alu_a, alu_b  out  32  — operands to the arithmetic unit.
- alu_f0, alu_f1  out  1  — function code to the arithmetic unit.
- alu_s  in  32  — arithmetic unit sum.
- alu_c  in  1  — arithmetic unit carry out.

## Operation
- States: IDLE → NEG_A → NEG_B → ITER (32 cycles, 5-bit counter) → NEG_LO → NEG_HI → DONE → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On accept, latch `a`, `b`, and `sgn = SIGNED_EN & signed_op`.
  - Latch `neg = sgn & (a[31]^b[31])`.
- **NEG_A**
  - If `sgn & a[31]`: drive f=10, alu_b=a; store `mcand <= alu_s`.
  - Otherwise: drive f=00, alu_a=0, alu_b=a (pass-through).
- **NEG_B**
  - Same as NEG_A, applied to b.
  - Result goes to `lo`; `hi <= 0`.
- **ITER**
  - Drive f=00, alu_a = `lo[0] ? mcand : 0`, alu_b=hi.
  - At the edge: `hi <= {alu_c, alu_s[31:1]}`, `lo <= {alu_s[0], lo[31:1]}`.
  - Exit after the 32nd iteration.
- **NEG_LO**
  - If neg: drive f=10, alu_b=lo; `lo <= alu_s`, `nc <= alu_c` (nc=1 iff lo was 0).
  - Otherwise: pass-through with f=00 and alu_a=0, and `nc <= 0`.
- **NEG_HI**
  - If neg: alu_b=~hi, f = nc ? 11 : 00 (with alu_a=0); `hi <= alu_s`.
  - Otherwise: pass-through of hi.
  - Load `prod <= {hi_new, lo}`.
- **DONE**
  - `out_valid`=1, `prod` held stable, `in_ready`=0.
  - On `out_ready`, go to IDLE.
- In IDLE and DONE, alu_a=alu_b=0 and f=00.
- Magnitude of 0x80000000 is 0x80000000 as an unsigned value; the product fits in 64 bits without special-casing.
- Reset values: `in_ready`=1, `out_valid`=0, `prod`=0, `alu_a`=`alu_b`=0, `alu_f0`=`alu_f1`=0, all internal registers 0, state IDLE.
- Reset mid-operation aborts immediately. There is no partial output and no stale `out_valid`.

## Timing
- E0 is the accept edge. Results are captured at E1 (NEG_A), E2 (NEG_B), E3..E34 (ITER), E35 (NEG_LO), E36 (NEG_HI).
- `out_valid` rises after E36. Accept to result is 36 cycles, independent of operand values.
- ALU outputs (`alu_*`) are combinational from state and registers. `alu_s`/`alu_c` are combinational returns sampled at the next edge.
- The clock period must exceed the unit's worst-case ripple delay. Gate-delay simulations use a period of ≥ 400 time units.
- `in_valid` is ignored outside IDLE.
- The result handshake completes at the edge with `out_valid & out_ready`. `in_ready` rises the following cycle, so back-to-back operations cost 38 cycles.
- `out_ready` held low stalls indefinitely; `prod` does not change.

## Test plan
- Unsigned: a=30, b=7 → prod=0x00000000_000000D2, `out_valid` exactly 36 cycles after accept, `in_ready`=0 meanwhile.
- Unsigned: a=b=0xFFFFFFFF → prod=0xFFFFFFFE_00000001.
- Signed: a=−3 (0xFFFFFFFD), b=7 → prod=0xFFFFFFFF_FFFFFFEB. Check alu f=10 during NEG_A and during NEG_LO.
- Signed: a=b=0x80000000 → prod=0x40000000_00000000. Signed a=0, b=−5 → prod=0, which exercises the nc=1 path with f=11 in NEG_HI.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `prod` stable, `in_ready`=0, `in_valid` pulses ignored. Release → IDLE next cycle, `in_ready`=1.
- Reset: assert `rst_n`=0 asynchronously mid-ITER (cycle 20) → `out_valid`=0, `prod`=0, `in_ready`=1 without a clock edge. A subsequent 5×6 unsigned operation returns 30 after 36 cycles.
